// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg : default 640x480@60 timing constants and coordinate helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  localparam int COORD_W   = 10;
  localparam int FRAME_C_W = 16;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync bundle bit positions inside the 2-bit delay line
  localparam int SYNC_HS_BIT = 0;
  localparam int SYNC_VS_BIT = 1;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic [FRAME_C_W-1:0] frame_cnt_t;

  // True when lo <= v < lo+len
  function automatic logic in_window(coord_t v, int lo, int len);
    int iv;
    iv = int'(v);
    return (iv >= lo) && (iv < lo + len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
// ----------------------------------------------------------------------------
// vga_timing_gen_if : raster coordinate, blank, sync and frame-event bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface vga_timing_gen_if;
  import vga_pkg::*;

  coord_t     DrawX;
  coord_t     DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic       vblank_start;
  frame_cnt_t frame_count;

  modport master (
    output DrawX, DrawY, blank, hs, vs, frame_start, vblank_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, frame_start, vblank_start, frame_count
  );

endinterface

`default_nettype wire

// File: rtl/vga_sync_delay.sv
// ----------------------------------------------------------------------------
// vga_sync_delay : DEPTH-stage {vs,hs} shift register, resets to all-ones
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_sync_delay #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sync_in,
  output logic [1:0] sync_out
);

  generate
    if (DEPTH == 0) begin : g_passthru
      // Clock and reset are intentionally idle at zero depth
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign sync_out       = sync_in;
    end else begin : g_shift
      logic [1:0] stage_q [DEPTH];
      logic [1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = sync_in;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= 2'b11;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign sync_out = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen : raster counters, registered blank/frame decodes, delayed syncs
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VIS      = DEF_H_VIS,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_VIS      = DEF_V_VIS,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int PIPE_DELAY = 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int     H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int     V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
  localparam coord_t V_VIS_C = coord_t'(V_VIS);

  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  logic       blank_q, blank_d;
  logic       frame_start_q, frame_start_d;
  logic       vblank_start_q, vblank_start_d;
  frame_cnt_t frame_count_q, frame_count_d;

  logic [1:0] sync_raw;
  logic [1:0] sync_dly;

  // Decodes look at the next count so they describe the pixel shown alongside them
  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end

    blank_d        = in_window(x_d, 0, H_VIS) && in_window(y_d, 0, V_VIS);
    frame_start_d  = (x_d == '0) && (y_d == '0);
    vblank_start_d = (x_d == '0) && (y_d == V_VIS_C);
    frame_count_d  = frame_count_q + frame_cnt_t'(frame_start_d);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q            <= H_LAST;
      y_q            <= V_LAST;
      blank_q        <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      blank_q        <= blank_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      frame_count_q  <= frame_count_d;
    end
  end

  // Raw syncs decode the live counters; the delay line realigns them to colour
  always_comb begin
    sync_raw              = 2'b11;
    sync_raw[SYNC_HS_BIT] = ~in_window(x_q, H_VIS + H_FP, H_SYNC);
    sync_raw[SYNC_VS_BIT] = ~in_window(y_q, V_VIS + V_FP, V_SYNC);
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DELAY)
  ) u_sync_delay (
    .clk      (vga_clk),
    .rst_n    (reset_n),
    .sync_in  (sync_raw),
    .sync_out (sync_dly)
  );

  assign vga.DrawX        = x_q;
  assign vga.DrawY        = y_q;
  assign vga.blank        = blank_q;
  assign vga.frame_start  = frame_start_q;
  assign vga.vblank_start = vblank_start_q;
  assign vga.frame_count  = frame_count_q;
  assign vga.hs           = sync_dly[SYNC_HS_BIT];
  assign vga.vs           = sync_dly[SYNC_VS_BIT];

endmodule

`default_nettype wire
